// File: rtl/mci_mem_responder.sv
// Memory-side responder for the memory controller interface.
// Services block-sized read/write requests from an internal block RAM and
// answers each one with a single-cycle ready pulse a fixed LATENCY cycles
// after the request was sampled. Used as the backing store behind the data
// cache in simulation and on FPGA.

package memory_controller_interface;

    localparam int MCI_ADDR_LENGTH = 32;
    localparam int MCI_DATA_LENGTH = 128;

    // Request from the cache initiator. addr is a byte address; rw = 1 is a write.
    typedef struct packed {
        logic [MCI_ADDR_LENGTH-1:0] addr;
        logic [MCI_DATA_LENGTH-1:0] data;
        logic                       rw;
        logic                       valid;
    } mci_request_t;

    // Response to the initiator. ready is a single-cycle pulse.
    typedef struct packed {
        logic [MCI_DATA_LENGTH-1:0] data;
        logic                       ready;
    } mci_response_t;

endpackage

module mci_mem_responder
    import memory_controller_interface::*;
#(
    parameter int DEPTH_BLOCKS = 16384,  // blocks stored, power of two, >= 2
    parameter int LATENCY      = 4       // request sample to ready pulse, >= 1
) (
    input  logic          clk,
    input  logic          rst,
    input  mci_request_t  mem_req,
    output mci_response_t mem_res,
    output logic          err
);

    // Byte offset within a block is dropped; the next IDX_BITS select the
    // block, and everything above is ignored so addresses wrap modulo the
    // RAM size.
    localparam int OFFSET_BITS = $clog2(MCI_DATA_LENGTH / 8);
    localparam int IDX_BITS    = $clog2(DEPTH_BLOCKS);

    // The counter holds LATENCY-1 at most; keep at least one bit so the
    // LATENCY == 1 build still has a well-formed (if unused) counter.
    localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    // With a one-cycle latency the WAIT phase is skipped entirely.
    localparam logic [1:0] S_ACCEPT  = (LATENCY == 1) ? S_RESPOND : S_WAIT;

    logic [1:0]                 state;
    logic [CNT_W-1:0]           cnt;
    logic [IDX_BITS-1:0]        lat_idx;
    logic [MCI_DATA_LENGTH-1:0] lat_data;
    logic                       lat_rw;

    logic [MCI_DATA_LENGTH-1:0] ram [DEPTH_BLOCKS];

    logic                       accept;
    logic                       commit;
    logic [IDX_BITS-1:0]        req_idx;
    logic                       unused_addr;

    // A new request is taken when idle, and also in the RESPOND cycle so the
    // cache can issue its refill read on the write-back's ready pulse.
    assign accept  = mem_req.valid && ((state == S_IDLE) || (state == S_RESPOND));
    assign req_idx = mem_req.addr[OFFSET_BITS+IDX_BITS-1 : OFFSET_BITS];

    // A write lands at the edge that closes its RESPOND cycle, unless reset
    // is asserted in that cycle, which drops the request.
    assign commit  = (state == S_RESPOND) && lat_rw && !rst;

    // Offset and high address bits are deliberately discarded.
    assign unused_addr = ^mem_req.addr;

    // Request tracking FSM: latch on accept, count down the latency, pulse ready.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            err      <= 1'b0;
            lat_idx  <= '0;
            lat_data <= '0;
            lat_rw   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_idx  <= req_idx;
                        lat_data <= mem_req.data;
                        lat_rw   <= mem_req.rw;
                        cnt      <= CNT_LOAD;
                        state    <= S_ACCEPT;
                    end
                end

                S_WAIT: begin
                    // A request arriving mid-flight is dropped and flagged;
                    // the in-flight request keeps its schedule.
                    if (mem_req.valid) begin
                        err <= 1'b1;
                    end
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= S_RESPOND;
                    end
                end

                S_RESPOND: begin
                    if (accept) begin
                        lat_idx  <= req_idx;
                        lat_data <= mem_req.data;
                        lat_rw   <= mem_req.rw;
                        cnt      <= CNT_LOAD;
                        state    <= S_ACCEPT;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Block RAM write port: full-block write at the end of a write's RESPOND cycle.
    always_ff @(posedge clk) begin
        // NOTE: the RAM is intentionally not reset; clearing it would defeat
        // block-RAM inference and the backing store must survive a reset.
        if (commit) begin
            ram[lat_idx] <= lat_data;
        end
    end

    // Response drive: ready and read data only in RESPOND, zero otherwise.
    always_comb begin
        // NOTE: assign a default first so every path drives every bit and no
        // latch is inferred.
        mem_res = '0;
        if ((state == S_RESPOND) && !rst) begin
            mem_res.ready = 1'b1;
            if (!lat_rw) begin
                mem_res.data = ram[lat_idx];
            end
        end
    end

endmodule

// File: tb/tb_mci_mem_responder.sv
// Self-checking bench for mci_mem_responder (LATENCY = 4, DEPTH_BLOCKS = 16).
// A table of single requests checks latency, data, offset masking and
// aliasing; hand-written sequences cover back-to-back traffic, the
// protocol-violation flag and reset during a write's response cycle.

module tb_mci_mem_responder;
    import memory_controller_interface::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 16;

    localparam logic [127:0] DATA_DEAD = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
    localparam logic [127:0] DATA_A    = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DATA_B    = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
    localparam logic [127:0] DATA_C    = 128'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0;
    localparam logic [127:0] DATA_D    = 128'h0D0D_0D0D_1234_5678_0D0D_0D0D_8765_4321;
    localparam logic [127:0] DATA_X    = 128'h5555_6666_7777_8888_9999_0000_1111_2222;
    localparam logic [127:0] DATA_Y    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic          clk;
    logic          rst;
    mci_request_t  mem_req;
    mci_response_t mem_res;
    logic          err;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        string        name;
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[9];

    mci_mem_responder #(
        .DEPTH_BLOCKS(DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_req(mem_req),
        .mem_res(mem_res),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge; valid is a one-cycle pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_req.valid = 1'b0;
    endtask

    task automatic issue(input logic rw, input logic [31:0] addr, input logic [127:0] data);
        mem_req.rw    = rw;
        mem_req.addr  = addr;
        mem_req.data  = data;
        mem_req.valid = 1'b1;
    endtask

    // Called in the issue cycle; returns in the cycle where ready must be high.
    task automatic wait_ready(input string name, input logic [127:0] exp);
        for (int i = 1; i < LAT; i++) begin
            tick();
            check($sformatf("%s early ready @+%0d", name, i), 128'(mem_res.ready), 128'(1'b0));
        end
        tick();
        check($sformatf("%s ready @+%0d", name, LAT), 128'(mem_res.ready), 128'(1'b1));
        check($sformatf("%s data", name), mem_res.data, exp);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0] = '{"wr 0x40",         1'b1, 32'h0000_0040, DATA_DEAD, 128'h0};
        vecs[1] = '{"rd 0x40",         1'b0, 32'h0000_0040, 128'h0,    DATA_DEAD};
        vecs[2] = '{"rd 0x4C offset",  1'b0, 32'h0000_004C, 128'h0,    DATA_DEAD};
        vecs[3] = '{"wr 0x10 A",       1'b1, 32'h0000_0010, DATA_A,    128'h0};
        vecs[4] = '{"wr 0x110 B",      1'b1, 32'h0000_0110, DATA_B,    128'h0};
        vecs[5] = '{"rd 0x10 alias",   1'b0, 32'h0000_0010, 128'h0,    DATA_B};
        vecs[6] = '{"rd 0x110",        1'b0, 32'h0000_0110, 128'h0,    DATA_B};
        vecs[7] = '{"wr 0x80 D",       1'b1, 32'h0000_0080, DATA_D,    128'h0};
        vecs[8] = '{"rd 0x80",         1'b0, 32'h0000_0080, 128'h0,    DATA_D};

        // Reset and idle quiet period.
        rst     = 1'b1;
        mem_req = '0;
        tick();
        tick();
        check("reset ready", 128'(mem_res.ready), 128'(1'b0));
        check("reset data",  mem_res.data, 128'h0);
        check("reset err",   128'(err), 128'(1'b0));
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle ready c%0d", i), 128'(mem_res.ready), 128'(1'b0));
            check($sformatf("idle data c%0d", i),  mem_res.data, 128'h0);
            check($sformatf("idle err c%0d", i),   128'(err), 128'(1'b0));
        end

        // Table of isolated requests: issue in N, ready in N+LAT, next in N+LAT+1.
        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].rw, vecs[v].addr, vecs[v].data);
            wait_ready(vecs[v].name, vecs[v].exp);
            tick();
            check($sformatf("%s ready drops", vecs[v].name), 128'(mem_res.ready), 128'(1'b0));
            check($sformatf("%s data drops", vecs[v].name),  mem_res.data, 128'h0);
        end

        // Back-to-back: write 0x200, write 0x100 on its ready, read 0x100 on that ready.
        issue(1'b1, 32'h0000_0200, DATA_X);
        wait_ready("b2b wr 0x200", 128'h0);
        issue(1'b1, 32'h0000_0100, DATA_Y);
        wait_ready("b2b wr 0x100", 128'h0);
        issue(1'b0, 32'h0000_0100, 128'h0);
        wait_ready("b2b rd 0x100", DATA_Y);
        tick();
        check("b2b idle after", 128'(mem_res.ready), 128'(1'b0));
        check("b2b err clear",  128'(err), 128'(1'b0));

        // Protocol violation: second valid two cycles into WAIT.
        issue(1'b0, 32'h0000_0040, 128'h0);
        tick();
        tick();
        check("viol err before", 128'(err), 128'(1'b0));
        issue(1'b0, 32'h0000_0080, 128'h0);
        tick();
        check("viol err set",      128'(err), 128'(1'b1));
        check("viol ready @+3",    128'(mem_res.ready), 128'(1'b0));
        tick();
        check("viol orig ready",   128'(mem_res.ready), 128'(1'b1));
        check("viol orig data",    mem_res.data, DATA_DEAD);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("viol no answer c%0d", i), 128'(mem_res.ready), 128'(1'b0));
            check($sformatf("viol err sticky c%0d", i), 128'(err), 128'(1'b1));
        end

        // Reset in the RESPOND cycle of a write of C to 0x80 (holds D).
        issue(1'b1, 32'h0000_0080, DATA_C);
        wait_ready("rst wr 0x80", 128'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst err cleared", 128'(err), 128'(1'b0));
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rst no ready c%0d", i), 128'(mem_res.ready), 128'(1'b0));
        end
        issue(1'b0, 32'h0000_0080, 128'h0);
        wait_ready("rst rd 0x80 keeps D", DATA_D);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
